// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS armed BCD alarm times checked once per second against
// the running clock, with a registered ring / snooze / auto-timeout FSM.

module alarm_bank_chan (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [7:0] hour_i,
  input  logic [7:0] min_i,
  input  logic       arm_i,
  input  logic [7:0] show_hour_i,
  input  logic [7:0] show_min_i,
  output logic       hit_o,
  output logic       arm_o
);
  logic [7:0] hour_q, min_q;
  logic       arm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q <= 8'h00;
      min_q  <= 8'h00;
      arm_q  <= 1'b0;
    end else if (we_i) begin
      hour_q <= hour_i;
      min_q  <= min_i;
      arm_q  <= arm_i;
    end
  end

  // Hour/minute equality only; the top qualifies it with sec_tick and :00.
  assign hit_o = arm_q && (hour_q == show_hour_i) && (min_q == show_min_i);
  assign arm_o = arm_q;
endmodule

module alarm_bank #(
  parameter  int NUM_ALARMS = 4,
  parameter  int RING_SECS  = 60,
  parameter  int SNOOZE_MIN = 5,
  localparam int IW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  _CR,
  input  logic                  sec_tick,
  input  logic [7:0]            show_hour,
  input  logic [7:0]            show_min,
  input  logic [7:0]            show_sec,
  input  logic                  set_en,
  input  logic [IW-1:0]         set_idx,
  input  logic [7:0]            set_hour,
  input  logic [7:0]            set_min,
  input  logic                  set_arm,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic                  ring,
  output logic [IW-1:0]         ring_idx,
  output logic                  snoozed,
  output logic [NUM_ALARMS-1:0] armed,
  output logic                  timeout
);
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  localparam logic [7:0] CNT_LAST = 8'(RING_SECS - 1);

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic [7:0]            tgt_hour_q, tgt_min_q;
  logic [7:0]            tgt_hour_d, tgt_min_d;
  logic [IW-1:0]         ring_idx_q;
  logic                  ring_q, snoozed_q, timeout_q;

  logic [NUM_ALARMS-1:0] we, hit, chan_arm;
  logic                  set_ok, kill, on_minute, match_any, tgt_hit;
  logic [IW-1:0]         win_idx;
  int                    snz_m, snz_h;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  assign set_ok = set_en && (int'(set_idx) < NUM_ALARMS);

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
    assign we[i] = set_ok && (int'(set_idx) == i);
    alarm_bank_chan u_chan (
      .clk         (clk),
      .rst_n       (_CR),
      .we_i        (we[i]),
      .hour_i      (set_hour),
      .min_i       (set_min),
      .arm_i       (set_arm),
      .show_hour_i (show_hour),
      .show_min_i  (show_min),
      .hit_o       (hit[i]),
      .arm_o       (chan_arm[i])
    );
  end

  assign on_minute = sec_tick && (show_sec == 8'h00);

  // Lowest matching index wins; scanning downward leaves the lowest last.
  always_comb begin
    match_any = 1'b0;
    win_idx   = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (on_minute && hit[i]) begin
        match_any = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end

  // Snooze target = current time + SNOOZE_MIN, done in binary and re-encoded.
  always_comb begin
    snz_m = bcd2int(show_min) + SNOOZE_MIN;
    snz_h = bcd2int(show_hour);
    if (snz_m >= 60) begin
      snz_m = snz_m - 60;
      snz_h = snz_h + 1;
    end
    if (snz_h >= 24) snz_h = 0;
    tgt_min_d  = int2bcd(snz_m);
    tgt_hour_d = int2bcd(snz_h);
  end

  assign tgt_hit = on_minute && (show_hour == tgt_hour_q) && (show_min == tgt_min_q);
  assign kill    = set_ok && (set_idx == ring_idx_q);

  always_ff @(posedge clk or negedge _CR) begin
    if (!_CR) begin
      state_q    <= IDLE;
      cnt_q      <= 8'h00;
      tgt_hour_q <= 8'h00;
      tgt_min_q  <= 8'h00;
      ring_idx_q <= '0;
      ring_q     <= 1'b0;
      snoozed_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (match_any) begin
            state_q    <= RINGING;
            ring_q     <= 1'b1;
            ring_idx_q <= win_idx;
            cnt_q      <= 8'h00;
          end
        end
        RINGING: begin
          if (dismiss || kill) begin
            state_q <= IDLE;
            ring_q  <= 1'b0;
          end else if (snooze) begin
            state_q    <= SNOOZED;
            ring_q     <= 1'b0;
            snoozed_q  <= 1'b1;
            tgt_hour_q <= tgt_hour_d;
            tgt_min_q  <= tgt_min_d;
          end else if (sec_tick) begin
            if (cnt_q == CNT_LAST) begin
              state_q   <= IDLE;
              ring_q    <= 1'b0;
              timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        SNOOZED: begin
          if (dismiss || kill) begin
            state_q   <= IDLE;
            snoozed_q <= 1'b0;
          end else if (tgt_hit || match_any) begin
            state_q   <= RINGING;
            ring_q    <= 1'b1;
            snoozed_q <= 1'b0;
            cnt_q     <= 8'h00;
            if (!tgt_hit) ring_idx_q <= win_idx;
          end
        end
        default: begin
          state_q   <= IDLE;
          ring_q    <= 1'b0;
          snoozed_q <= 1'b0;
        end
      endcase
    end
  end

  assign ring     = ring_q;
  assign ring_idx = ring_idx_q;
  assign snoozed  = snoozed_q;
  assign timeout  = timeout_q;
  assign armed    = chan_arm;
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Multi-channel alarm controller for the digital clock. It holds NUM_ALARMS independently armed alarm times (BCD hour/minute) and compares them against the running clock once per second. It drives a single ring output with the index of the firing channel, and supports snooze, dismiss and an automatic ring timeout. It sits between the timekeeping counter (show_hour/show_min/show_sec, sec_tick) and the light/buzzer driver. It supersedes the single combinational alarm compare with a registered, multi-alarm FSM.

## Interface
Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..16)
- RING_SECS, 60, sec_ticks a ring lasts before auto-stop (1..255)
- SNOOZE_MIN, 5, snooze length in minutes (1..59)
- IW = max(1, $clog2(NUM_ALARMS)), derived index width

Ports:
- clk  in  1  system clock; one clock, all state on its rising edge
- _CR  in  1  reset, asynchronous, active-low
- sec_tick  in  1  one-cycle pulse; time inputs hold the new second on this cycle
- show_hour  in  8  current hour, BCD 00..23
- show_min  in  8  current minute, BCD 00..59
- show_sec  in  8  current second, BCD 00..59
- set_en  in  1  write pulse for channel set_idx
- set_idx  in  IW  channel to write
- set_hour  in  8  BCD hour to store
- set_min  in  8  BCD minute to store
- set_arm  in  1  armed bit to store with the time
- snooze  in  1  request snooze of the ringing alarm
- dismiss  in  1  request stop of ringing or snoozed alarm
- ring  out  1  alarm active (drives light/buzzer)
- ring_idx  out  IW  channel currently ringing or snoozed
- snoozed  out  1  snooze pending
- armed  out  NUM_ALARMS  per-channel armed bits
- timeout  out  1  one-cycle pulse when a ring auto-stops

## Operation
- Per channel registers: hour[7:0], min[7:0], arm. Write on set_en: all three are written to channel set_idx. The write is visible from the next cycle. A set_idx >= NUM_ALARMS is ignored.
- Match for channel i: arm[i] && hour[i]==show_hour && min[i]==show_min && show_sec==8'h00, evaluated only on the sec_tick cycle.
- Multiple channels matching on the same tick: the lowest index wins and the others are dropped.
- FSM states:
  - IDLE:
    - any match -> RINGING, ring_idx=winner, ring counter cleared.
  - RINGING:
    - dismiss -> IDLE.
    - else snooze -> SNOOZED, snooze target = show time + SNOOZE_MIN.
    - else sec_tick with counter == RING_SECS-1 -> IDLE and pulse timeout.
    - else sec_tick increments the counter.
  - SNOOZED:
    - dismiss -> IDLE.
    - else sec_tick with show_hour/show_min == target and show_sec==00 -> RINGING, same ring_idx, counter cleared.
    - else any channel match -> RINGING with the new winner; the pending snooze is discarded.
- Snooze arithmetic is BCD:
  - min + SNOOZE_MIN; if >= 60, subtract 60 and carry 1 hour.
  - hour 23 + carry wraps to 00. Example: 23:58 + 5 -> 00:03.
- Priority within one cycle:
  - dismiss > snooze > timeout/match.
  - set_en that disarms or rewrites channel ring_idx while in RINGING or SNOOZED forces IDLE next cycle; this has priority over snooze.
- Matches in RINGING are ignored; the current ring continues.
- Outputs:
  - ring = (state==RINGING).
  - snoozed = (state==SNOOZED).
  - armed = arm bits.
  - ring_idx holds its last value in IDLE.
- Reset (_CR low, asynchronous):
  - state IDLE; all times 00:00; all arm 0.
  - ring=0, ring_idx=0, snoozed=0, timeout=0, armed=0, counter=0, snooze target=00:00.
  - Reset mid-ring ends the ring immediately.

## Timing
- All outputs are registered.
- ring rises 1 cycle after the matching sec_tick cycle.
- ring falls 1 cycle after the dismiss, snooze, set_en or timeout cycle.
- timeout is high for exactly 1 cycle, coincident with ring falling.
- Ring duration is exactly RING_SECS sec_ticks counted after the start tick.
- snooze/dismiss are level-sampled each cycle and are effective only in the states listed above; otherwise ignored.
- Time inputs are sampled only on sec_tick cycles; values between ticks are don't-care.
- No handshake back to the time source.

## Test plan
- Arm ch2 at 07:30 via set_en, drive ticks 07:29:59 -> 07:30:00: ring=1 and ring_idx=2 one cycle after the tick. ch2 disarmed at the same time -> no ring.
- Ch0 and ch3 both armed at 12:00 and ticked to 12:00:00: ring_idx=0; ch3 never rings that minute.
- Ring at 23:58:00, snooze on 23:58:10: snoozed=1, ring=0. Ticking to 00:03:00 gives ring=1 with the same ring_idx. Snooze and dismiss in the same cycle -> IDLE, snoozed=0.
- RING_SECS=60, no user input: timeout pulses once on the 60th tick after the start, ring=0 afterwards. Dismiss on tick 59 -> no timeout pulse.
- While SNOOZED on ch1, ch2 matches: ring=1, ring_idx=2, snoozed=0.
- Assert _CR low mid-ring, asynchronously and between clock edges: ring, snoozed and armed go to 0 immediately, and all alarm times read back 00:00 disarmed.
